// File: rtl/mips_ins_loader.sv
// mips_ins_loader: program loader for SingleCycleClockMIPS.
// Receives a byte stream over valid/ready and packs each group of four
// bytes, most-significant byte first, into one 32-bit word. Each word is
// written to instruction memory with a one-cycle WE pulse at W_Addr. The
// CPU is held in reset until the whole program has been written.
//
// Optional feature: define LOADER_CHECKSUM_EN to expect one extra word
// after the program. It must equal the mod-2^32 sum of the program words,
// otherwise the loader parks in ERR with err=1 and the CPU still in reset.
//
// Ports:
//   CLK, RST     clock; synchronous active-high reset
//   start        begin a load session (honoured in IDLE, RUN, ERR)
//   num_words    program length in words, latched on an accepted start
//   in_valid     byte available on in_data
//   in_data      program byte
//   in_ready     loader accepts a byte this cycle
//   W_Ins        instruction word, stable while WE=1
//   W_Addr       word address of W_Ins
//   WE           one-cycle instruction-memory write strobe per word
//   CPU_RST      reset to the CPU, high while loading
//   busy         high while receiving/writing
//   done         high once the program is loaded and the CPU runs
//   err          checksum failure (always 0 without LOADER_CHECKSUM_EN)
module mips_ins_loader #(
  parameter int unsigned AW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [AW-1:0] num_words,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [31:0]   W_Ins,
  output logic [AW-1:0] W_Addr,
  output logic          WE,
  output logic          CPU_RST,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state;
  logic [AW-1:0]     count;
  logic [BCNT_W-1:0] byte_cnt;

  logic              accept_c;
  logic              last_c;
  logic              nonzero_c;
  logic [WORD_W-1:0] word_next_c;

  // Byte handshake, shifted word, last-address and empty-program detection.
  assign accept_c    = in_valid && in_ready;
  assign word_next_c = {W_Ins[23:0], in_data};
  assign last_c      = (W_Addr == AW'(count - AW'(1)));
  assign nonzero_c   = (num_words != '0);

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  logic              chk_phase;
`else
  assign err = 1'b0;
`endif

  // Loader FSM; W_Ins doubles as the byte shift register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      byte_cnt <= '0;
      W_Ins    <= '0;
      W_Addr   <= '0;
      WE       <= 1'b0;
      in_ready <= 1'b0;
      CPU_RST  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err       <= 1'b0;
      sum       <= '0;
      chk_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            count    <= num_words;
            W_Addr   <= '0;
            byte_cnt <= '0;
            // An empty program goes straight to RUN and lets the CPU go.
            state    <= nonzero_c ? RECV : RUN;
            in_ready <= nonzero_c;
            busy     <= nonzero_c;
            CPU_RST  <= nonzero_c;
            done     <= !nonzero_c;
`ifdef LOADER_CHECKSUM_EN
            err       <= 1'b0;
            sum       <= '0;
            chk_phase <= 1'b0;
`endif
          end
        end

        RECV: begin
          if (accept_c) begin
            W_Ins    <= word_next_c;
            byte_cnt <= BCNT_W'(byte_cnt + BCNT_W'(1));
            if (byte_cnt == BCNT_W'(3)) begin
              byte_cnt <= '0;
              in_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              if (chk_phase) begin
                // Checksum word: decide, never written to memory.
                busy <= 1'b0;
                if (word_next_c == sum) begin
                  state   <= RUN;
                  CPU_RST <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  state <= ERR;
                  err   <= 1'b1;
                end
              end else begin
                state <= WRITE;
                WE    <= 1'b1;
              end
`else
              state <= WRITE;
              WE    <= 1'b1;
`endif
            end
          end
        end

        WRITE: begin
          WE <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum <= sum + W_Ins;
`endif
          if (last_c) begin
`ifdef LOADER_CHECKSUM_EN
            // Collect the checksum word at an unchanged address.
            chk_phase <= 1'b1;
            state     <= RECV;
            in_ready  <= 1'b1;
`else
            state   <= RUN;
            CPU_RST <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
`endif
          end else begin
            W_Addr   <= AW'(W_Addr + AW'(1));
            state    <= RECV;
            in_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ins_loader.sv
// Bench for mips_ins_loader: table of load sessions plus hand-written
// mid-word reset sequence; writes checked through a scoreboard queue.
module tb_mips_ins_loader;

  localparam int unsigned AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [AW-1:0] num_words;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [31:0]   W_Ins;
  logic [AW-1:0] W_Addr;
  logic          WE;
  logic          CPU_RST;
  logic          busy;
  logic          done;
  logic          err;

  mips_ins_loader #(.AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .W_Ins     (W_Ins),
    .W_Addr    (W_Addr),
    .WE        (WE),
    .CPU_RST   (CPU_RST),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  typedef struct packed {
    logic [7:0]       n;
    logic [2:0][31:0] w;
    logic             tog;     // in_valid low every other cycle
    logic             glitch;  // pulse start while receiving
    logic             bad;     // corrupt checksum word
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   errors   = 0;
  int   we_count = 0;
  int   accepted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every WE pulse must match the oldest expected write.
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      exp_t e;
      we_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL we_unexpected: got WE at addr %0h data %0h, expected no write", W_Addr, W_Ins);
      end else begin
        e = sb.pop_front();
        chk("we_addr", 64'(W_Addr), 64'(e.addr));
        chk("we_data", 64'(W_Ins), 64'(e.data));
      end
    end
  end

  // Offer one byte; entered and left #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic tog);
    int  waited = 0;
    bit  ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && waited < 50) begin
      if (in_ready === 1'b1) ok = 1;
      @(posedge CLK); #1;
      waited++;
    end
    if (!ok) chk("byte_timeout", 64'(0), 64'(1));
    else accepted++;
    if (tog) begin
      in_valid = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(posedge CLK); #1;
    start = 1'b1;
    num_words = n;
    @(posedge CLK); #1;
    start = 1'b0;
    num_words = 8'hAA;
  endtask

  task automatic check_reset_vals();
    chk("rst_cpu_rst", 64'(CPU_RST), 64'(1));
    chk("rst_we",      64'(WE), 64'(0));
    chk("rst_w_ins",   64'(W_Ins), 64'(0));
    chk("rst_w_addr",  64'(W_Addr), 64'(0));
    chk("rst_in_ready",64'(in_ready), 64'(0));
    chk("rst_busy",    64'(busy), 64'(0));
    chk("rst_done",    64'(done), 64'(0));
    chk("rst_err",     64'(err), 64'(0));
  endtask

  task automatic load(input vec_t v);
    int          acc0 = accepted;
    int          we0  = we_count;
    int          nchk = 0;
    logic [31:0] sum  = 32'h0;
    logic [7:0]  bt;
    pulse_start(v.n);
    // Now #1 after the edge that sampled start.
    if (v.n == 0) begin
      chk("zero_done",    64'(done), 64'(1));
      chk("zero_cpu_rst", 64'(CPU_RST), 64'(0));
      chk("zero_busy",    64'(busy), 64'(0));
      return;
    end
    chk("start_cpu_rst", 64'(CPU_RST), 64'(1));
    chk("start_busy",    64'(busy), 64'(1));
    chk("start_done",    64'(done), 64'(0));
    for (int i = 0; i < int'(v.n); i++) begin
      sum = sum + v.w[i];
      for (int b = 0; b < 4; b++) begin
        bt = v.w[i][(31 - 8 * b) -: 8];
        if (b == 3) sb.push_back('{addr: AW'(i), data: v.w[i]});
        send_byte(bt, v.tog);
        if (v.glitch && i == 0 && b == 0) begin
          in_valid = 1'b0;
          pulse_start(8'd5);
        end
      end
    end
    in_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (!v.tog) begin
      chk("last_we", 64'(WE), 64'(1));
      @(posedge CLK); #1;
      chk("chk_phase_cpu_rst", 64'(CPU_RST), 64'(1));
    end
    if (v.bad) sum = sum + 32'd1;
    for (int b = 0; b < 4; b++) begin
      bt = sum[(31 - 8 * b) -: 8];
      send_byte(bt, 1'b0);
    end
    in_valid = 1'b0;
    if (v.tog) begin
      @(posedge CLK); #1;
    end
    nchk = 4;
    chk("end_err",      64'(err), 64'(v.bad));
    chk("end_cpu_rst",  64'(CPU_RST), 64'(v.bad));
    chk("end_done",     64'(done), 64'(!v.bad));
    chk("end_in_ready", 64'(in_ready), 64'(0));
`else
    if (!v.tog) begin
      chk("last_we", 64'(WE), 64'(1));
      chk("last_we_cpu_rst", 64'(CPU_RST), 64'(1));
      @(posedge CLK); #1;
    end
    chk("end_cpu_rst", 64'(CPU_RST), 64'(0));
    chk("end_done",    64'(done), 64'(1));
    chk("end_busy",    64'(busy), 64'(0));
`endif
    repeat (2) @(posedge CLK);
    #1;
    chk("bytes_accepted", 64'(accepted - acc0), 64'(4 * int'(v.n) + nchk));
    chk("we_pulses",      64'(we_count - we0), 64'(v.n));
    chk("sb_drained",     64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    vecs[0] = '{n: 8'd2, w: {32'h0, 32'h00000008, 32'h20100005}, tog: 1'b0, glitch: 1'b0, bad: 1'b0};
    vecs[1] = '{n: 8'd2, w: {32'h0, 32'h00000008, 32'h20100005}, tog: 1'b1, glitch: 1'b0, bad: 1'b0};
    vecs[2] = '{n: 8'd0, w: '0, tog: 1'b0, glitch: 1'b0, bad: 1'b0};
    vecs[3] = '{n: 8'd3, w: {32'h89abcdef, 32'h01234567, 32'hdeadbeef}, tog: 1'b0, glitch: 1'b1, bad: 1'b0};
    vecs[4] = '{n: 8'd2, w: {32'h0, 32'h00000002, 32'h00000001}, tog: 1'b0, glitch: 1'b0, bad: 1'b0};
    vecs[5] = '{n: 8'd2, w: {32'h0, 32'h00000002, 32'h00000001}, tog: 1'b0, glitch: 1'b0, bad: 1'b1};
    vecs[6] = '{n: 8'd1, w: {32'h0, 32'h0, 32'h11223344}, tog: 1'b1, glitch: 1'b0, bad: 1'b0};

    RST = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals();
    RST = 1'b0;

    // Reset after two bytes of the first word: nothing written, all cleared.
    we0 = we_count;
    pulse_start(8'd2);
    send_byte(8'h20, 1'b0);
    send_byte(8'h10, 1'b0);
    in_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_vals();
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("midreset_no_we", 64'(we_count - we0), 64'(0));
    chk("midreset_in_ready", 64'(in_ready), 64'(0));

    for (int k = 0; k < 7; k++) load(vecs[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
